// File: rtl/i2c_target.sv
// I2C target: 7-bit address, oversampled SCL/SDA, open-drain SDA.
// Receives write bytes to user logic and shifts out user-supplied read bytes.
module i2c_target #(
   parameter int                    ADDR_WIDTH  = 7,
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  scl,
   inout  tri                    sda,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_underrun,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  read_active
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
   } state_t;

   localparam logic [3:0] LAST = 4'(DATA_WIDTH - 1);
   localparam logic [3:0] FULL = 4'(DATA_WIDTH);

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_d, sda_d;
   logic                   scl_s, sda_s;
   logic                   start, stop, rise, fall;

   state_t                 state, state_n;
   logic [3:0]             bit_cnt, cnt_n, cnt_inc;
   logic [DATA_WIDTH-1:0]  shift, shift_n, shift_in, tx_byte;
   logic                   sda_oe, oe_n;
   logic                   busy_n, rd_n, acked, acked_n, load;
   logic [DATA_WIDTH-1:0]  rx_data_n;
   logic                   rx_valid_n, tx_ready_n, under_n;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];
   assign start = sda_d & ~sda_s & scl_s;
   assign stop  = ~sda_d & sda_s & scl_s;
   assign rise  = scl_s & ~scl_d;
   assign fall  = ~scl_s & scl_d;

   assign sda = sda_oe ? 1'b0 : 1'bz;

   assign shift_in = {shift[DATA_WIDTH-2:0], sda_s};
   assign cnt_inc  = (bit_cnt == FULL) ? FULL : bit_cnt + 4'd1;
   assign tx_byte  = tx_valid ? tx_data : '1;

   // Input synchronizers; reset to the idle-high bus level to avoid false edges.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   // Protocol state and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         sda_oe      <= 1'b0;
         busy        <= 1'b0;
         read_active <= 1'b0;
         acked       <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_ready    <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         state       <= state_n;
         bit_cnt     <= cnt_n;
         shift       <= shift_n;
         sda_oe      <= oe_n;
         busy        <= busy_n;
         read_active <= rd_n;
         acked       <= acked_n;
         rx_data     <= rx_data_n;
         rx_valid    <= rx_valid_n;
         tx_ready    <= tx_ready_n;
         tx_underrun <= under_n;
      end
   end

   // Next-state logic; START/STOP override whatever the state is doing.
   always_comb begin
      state_n    = state;
      cnt_n      = bit_cnt;
      shift_n    = shift;
      oe_n       = sda_oe;
      busy_n     = busy;
      rd_n       = read_active;
      acked_n    = acked;
      rx_data_n  = rx_data;
      rx_valid_n = 1'b0;
      tx_ready_n = 1'b0;
      under_n    = 1'b0;
      load       = 1'b0;
      if (start) begin
         state_n = ADDR;
         cnt_n   = '0;
         oe_n    = 1'b0;
      end else if (stop) begin
         state_n = IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else begin
         unique case (state)
            IDLE: oe_n = 1'b0;
            ADDR: begin
               if (rise) begin
                  shift_n = shift_in;
                  cnt_n   = cnt_inc;
                  if (bit_cnt == LAST) begin
                     if (shift_in[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR) begin
                        busy_n = 1'b1;
                        rd_n   = shift_in[0];
                     end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                     end
                  end
               end else if (fall && bit_cnt == FULL) begin
                  oe_n    = 1'b1;
                  state_n = ADDR_ACK;
               end
            end
            ADDR_ACK: begin
               if (fall) begin
                  if (read_active) begin
                     load = 1'b1;
                  end else begin
                     oe_n    = 1'b0;
                     cnt_n   = '0;
                     state_n = WRITE;
                  end
               end
            end
            WRITE: begin
               if (rise) begin
                  shift_n = shift_in;
                  cnt_n   = cnt_inc;
                  if (bit_cnt == LAST) begin
                     rx_data_n  = shift_in;
                     rx_valid_n = 1'b1;
                  end
               end else if (fall && bit_cnt == FULL) begin
                  oe_n    = 1'b1;
                  state_n = WRITE_ACK;
               end
            end
            WRITE_ACK: begin
               if (fall) begin
                  oe_n    = 1'b0;
                  cnt_n   = '0;
                  state_n = WRITE;
               end
            end
            READ: begin
               if (fall) begin
                  if (bit_cnt == FULL) begin
                     oe_n    = 1'b0;
                     acked_n = 1'b0;
                     state_n = READ_ACK;
                  end else begin
                     shift_n = {shift[DATA_WIDTH-2:0], 1'b0};
                     oe_n    = ~shift[DATA_WIDTH-2];
                     cnt_n   = cnt_inc;
                  end
               end
            end
            READ_ACK: begin
               if (rise) begin
                  if (!sda_s) begin
                     acked_n = 1'b1;
                  end else begin
                     busy_n  = 1'b0;
                     state_n = IDLE;
                  end
               end else if (fall && acked) begin
                  load = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      if (load) begin
         shift_n    = tx_byte;
         oe_n       = ~tx_byte[DATA_WIDTH-1];
         cnt_n      = 4'd1;
         tx_ready_n = 1'b1;
         under_n    = ~tx_valid;
         state_n    = READ;
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller plus a transaction-level
// reference model (ACK iff address matches, bytes in = bytes out).
module tb_i2c_target;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       scl;
   logic       ctl_low;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_underrun, rx_valid, busy, read_active;
   logic [7:0] rx_data;
   wire        sda_bus;

   pullup (sda_bus);
   assign sda_bus = ctl_low ? 1'b0 : 1'bz;

   i2c_target dut (
      .clock(clock), .reset_n(reset_n), .scl(scl), .sda(sda_bus),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .read_active(read_active)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   logic [7:0] rx_hist[$];
   int n_tx = 0, n_und = 0, n_alone = 0, n_both = 0, n_drive = 0;

   // Cumulative event counters sampled at the clock edge.
   always @(posedge clock) begin
      if (rx_valid) rx_hist.push_back(rx_data);
      if (tx_ready) n_tx++;
      if (tx_underrun) n_und++;
      if (tx_underrun && !tx_ready) n_alone++;
      if (rx_valid && tx_ready) n_both++;
      if (!ctl_low && sda_bus === 1'b0) n_drive++;
   end

   logic [7:0] wdata[4];
   logic [7:0] tdata[4];
   logic       tvalid[4];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic q();
      repeat (10) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b, output logic seen);
      ctl_low = ~b; q();
      scl = 1'b1;   q();
      seen = sda_bus;
      q();
      scl = 1'b0;   q();
   endtask

   task automatic bus_start();
      ctl_low = 1'b0; q();
      scl = 1'b1;     q();
      ctl_low = 1'b1; q();
      scl = 1'b0;     q();
   endtask

   task automatic bus_stop();
      ctl_low = 1'b1; q();
      scl = 1'b1;     q();
      ctl_low = 1'b0; q();
      q();
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i], b);
      send_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic nack, input logic [7:0] nd,
                            input logic nv, output logic [7:0] d);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, b);
         d = {d[6:0], b};
      end
      tx_data = nd; tx_valid = nv;
      send_bit(nack, b);
   endtask

   task automatic txn(input logic [6:0] a, input logic rw, input int n,
                      input logic do_stop);
      logic       ack, match;
      logic [7:0] d, exp_b;
      int         exp_und, rx0, tx0, und0, alone0, both0, drv0;
      match  = (a == 7'h42);
      rx0    = rx_hist.size();
      tx0    = n_tx; und0 = n_und; alone0 = n_alone;
      both0  = n_both; drv0 = n_drive;
      exp_und = 0;
      tx_data = tdata[0]; tx_valid = tvalid[0];
      bus_start();
      send_byte({a, rw}, ack);
      chk("addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
      chk("busy_addr", 32'(busy), 32'(match));
      if (match) chk("read_active", 32'(read_active), 32'(rw));
      if (!rw) begin
         for (int i = 0; i < n; i++) begin
            send_byte(wdata[i], ack);
            chk("wr_ack", 32'(ack), match ? 32'd0 : 32'd1);
         end
      end else if (match) begin
         for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, tdata[i+1], tvalid[i+1], d);
            exp_b = tvalid[i] ? tdata[i] : 8'hFF;
            if (!tvalid[i]) exp_und++;
            chk("rd_byte", 32'(d), 32'(exp_b));
         end
         chk("busy_nack", 32'(busy), 32'd0);
         chk("sda_rel_nack", 32'(sda_bus), 32'd1);
      end
      if (do_stop) begin
         bus_stop();
         chk("busy_stop", 32'(busy), 32'd0);
      end
      chk("rx_count", 32'(rx_hist.size() - rx0),
          (match && !rw) ? 32'(n) : 32'd0);
      if (match && !rw)
         for (int i = 0; i < n; i++)
            if (rx0 + i < rx_hist.size())
               chk("rx_byte", 32'(rx_hist[rx0+i]), 32'(wdata[i]));
      chk("tx_ready_cnt", 32'(n_tx - tx0), (match && rw) ? 32'(n) : 32'd0);
      chk("underrun_cnt", 32'(n_und - und0), 32'(exp_und));
      chk("underrun_alone", 32'(n_alone - alone0), 32'd0);
      chk("rx_tx_same", 32'(n_both - both0), 32'd0);
      if (!match) chk("no_drive", 32'(n_drive - drv0), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sda"}, 32'(sda_bus), 32'd1);
      chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
      chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
      chk({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rd"}, 32'(read_active), 32'd0);
   endtask

   initial begin
      logic       ack, b;
      logic [6:0] a;
      int         n;
      reset_n = 1'b0; scl = 1'b1; ctl_low = 1'b0;
      tx_data = '0; tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wdata[i] = '0; tdata[i] = '0; tvalid[i] = 1'b1;
      end
      repeat (3) @(posedge clock);
      #1;
      chk_reset_vals("reset");
      reset_n = 1'b1;
      q();

      wdata[0] = 8'hA5;
      txn(7'h42, 1'b0, 1, 1'b1);
      chk("t1_rx_data", 32'(rx_data), 32'hA5);

      wdata[0] = 8'h11;
      txn(7'h43, 1'b0, 1, 1'b1);

      tdata[0] = 8'h3C; tdata[1] = 8'h81; tdata[2] = 8'h00;
      tvalid[0] = 1'b1; tvalid[1] = 1'b1; tvalid[2] = 1'b1;
      txn(7'h42, 1'b1, 2, 1'b1);

      tdata[0] = 8'h77; tvalid[0] = 1'b0; tvalid[1] = 1'b1;
      txn(7'h42, 1'b1, 1, 1'b1);

      wdata[0] = 8'h5A;
      txn(7'h42, 1'b0, 1, 1'b0);
      chk("t5_busy_no_stop", 32'(busy), 32'd1);
      tdata[0] = 8'hE7; tvalid[0] = 1'b1;
      txn(7'h42, 1'b1, 1, 1'b1);
      chk("t5_rx_data", 32'(rx_data), 32'h5A);

      tdata[0] = 8'h00; tvalid[0] = 1'b1;
      tx_data = 8'h00; tx_valid = 1'b1;
      bus_start();
      send_byte({7'h42, 1'b1}, ack);
      chk("t6_addr_ack", 32'(ack), 32'd0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, b);
      chk("t6_driving", 32'(sda_bus), 32'd0);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("t6");
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      q();
      scl = 1'b1;
      q();
      wdata[0] = 8'hC3;
      txn(7'h42, 1'b0, 1, 1'b1);

      for (int t = 0; t < 14; t++) begin
         a = ($urandom_range(0, 2) != 0) ? 7'h42 : 7'($urandom_range(0, 127));
         n = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++) begin
            wdata[i]  = 8'($urandom);
            tdata[i]  = 8'($urandom);
            tvalid[i] = ($urandom_range(0, 3) != 0);
         end
         txn(a, 1'($urandom_range(0, 1)), n, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
